// File: rtl/stream_maxpool2x2.sv
// stream_maxpool2x2: AXI-Stream 2x2/stride-2 signed int8 max-pool, one half-row buffer.
// Define MAXPOOL_RELU_EN to clamp every input byte to max(x,0) before pooling.
module stream_maxpool2x2 #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_FLEN = 32
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic                              start,
  input  logic [5:0]                        flen,
  input  logic [8:0]                        num_ch,
  output logic                              done,
  output logic                              err,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [3:0]                        S_AXIS_TKEEP,
  input  logic                              S_AXIS_TUSER,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [3:0]                        M_AXIS_TKEEP,
  output logic                              M_AXIS_TUSER,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID
);
  localparam int CW = $clog2(MAX_FLEN / 4);
  localparam logic [6:0] MAXF = 7'(MAX_FLEN);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [5:0] flen_r, row;
  logic [8:0] nch_r, plane;
  logic [CW-1:0] col;
  logic in_done;
  logic [MAX_FLEN*4-1:0] rowbuf;
  logic [15:0] stage, rb;
  logic [7:0] b [4];
  logic [7:0] h0, h1, p0, p1;
  logic col_last, row_last, plane_last, final_w, s_fire, m_fire, legal, load;
  logic unused;
  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] c);
    return ($signed(a) >= $signed(c)) ? a : c;
  endfunction
  function automatic logic [7:0] pre(input logic [7:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction
  assign unused = ^{S_AXIS_TKEEP, S_AXIS_TUSER};
  assign M_AXIS_TKEEP = 4'hF;
  assign M_AXIS_TUSER = 1'b0;
  assign col_last = col == CW'(flen_r[5:2] - 4'd1);
  assign row_last = row == flen_r - 6'd1;
  assign plane_last = plane == nch_r - 9'd1;
  assign final_w = col_last && row_last && plane_last;
  assign legal = flen[2:0] == 3'b0 && flen != 6'd0 && {1'b0, flen} <= MAXF && num_ch != 9'd0;
  // Odd rows stall only on the word that would overwrite a still-full output register.
  assign S_AXIS_TREADY = state == RUN && !in_done &&
                         (!row[0] || !M_AXIS_TVALID || M_AXIS_TREADY || !col[0]);
  assign s_fire = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_fire = M_AXIS_TVALID && M_AXIS_TREADY;
  assign load = s_fire && row[0] && col[0];
  always_comb begin
    for (int i = 0; i < 4; i++) b[i] = pre(S_AXIS_TDATA[8*i +: 8]);
    h0 = smax(b[0], b[1]);
    h1 = smax(b[2], b[3]);
    rb = rowbuf[{col, 4'b0} +: 16];
    p0 = smax(h0, rb[7:0]);
    p1 = smax(h1, rb[15:8]);
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      flen_r <= '0;
      nch_r <= '0;
      col <= '0;
      row <= '0;
      plane <= '0;
      in_done <= 1'b0;
      rowbuf <= '0;
      stage <= '0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err <= !legal;
          if (legal) begin
            flen_r <= flen;
            nch_r <= num_ch;
            col <= '0;
            row <= '0;
            plane <= '0;
            in_done <= 1'b0;
            state <= RUN;
          end
        end
        RUN: if (m_fire && M_AXIS_TLAST) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (s_fire) begin
        if (S_AXIS_TLAST != final_w) err <= 1'b1;
        if (!row[0]) rowbuf[{col, 4'b0} +: 16] <= {h1, h0};
        else if (!col[0]) stage <= {p1, p0};
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row <= row_last ? 6'd0 : row + 6'd1;
          if (row_last) begin
            plane <= plane + 9'd1;
            in_done <= plane_last;
          end
        end
      end
      M_AXIS_TVALID <= load || (M_AXIS_TVALID && !M_AXIS_TREADY);
      if (load) begin
        M_AXIS_TDATA <= {p1, p0, stage};
        M_AXIS_TLAST <= final_w;
      end else if (m_fire) M_AXIS_TLAST <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_maxpool2x2.sv
// tb_stream_maxpool2x2: directed self-checking bench for stream_maxpool2x2.
module tb_stream_maxpool2x2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0] flen = '0;
  logic [8:0] num_ch = '0;
  logic done, err, s_tready, m_tlast, m_tvalid, m_tuser;
  logic [31:0] s_tdata = '0, m_tdata;
  logic [3:0] m_tkeep;
  logic s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b1;
  int n_checks = 0, n_fail = 0;
  logic [7:0] px [3][32][32];
  logic [31:0] got_q [$];
  bit done_seen;

  stream_maxpool2x2 dut (
    .CLK(clk), .RESETN(rst_n), .start(start), .flen(flen), .num_ch(num_ch),
    .done(done), .err(err), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TKEEP(4'hF), .S_AXIS_TUSER(1'b0), .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep),
    .M_AXIS_TUSER(m_tuser), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] relu(input logic [7:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] exp_word(input int p, input int pr, input int pw);
    logic [31:0] w;
    logic [7:0] m, v;
    int pc;
    for (int j = 0; j < 4; j++) begin
      pc = pw * 4 + j;
      m = relu(px[p][2*pr][2*pc]);
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          v = relu(px[p][2*pr+dy][2*pc+dx]);
          if ($signed(v) > $signed(m)) m = v;
        end
      w[8*j +: 8] = m;
    end
    return w;
  endfunction

  task automatic pulse_start(input int f, input int n);
    @(negedge clk);
    start = 1'b1;
    flen = 6'(f);
    num_ch = 9'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic present(input int f, input int ii, input int total_in, input int bad);
    int wpp, p, r, c;
    wpp = f * f / 4;
    p = ii / wpp;
    r = (ii / (f / 4)) % f;
    c = ii % (f / 4);
    s_tvalid = 1'b1;
    s_tdata = {px[p][r][4*c+3], px[p][r][4*c+2], px[p][r][4*c+1], px[p][r][4*c]};
    s_tlast = (ii == total_in - 1) ^ (ii == bad);
  endtask

  task automatic run_frame(input int f, input int n, input bit rnd, input int bad);
    int total_in, total_out, ii, k, wpp, p, rem;
    bit hold, s_fire, m_fire;
    logic [31:0] held, e;
    total_in = n * f * f / 4;
    total_out = n * f * f / 16;
    wpp = f * f / 16;
    ii = 0;
    k = 0;
    hold = 0;
    held = '0;
    got_q.delete();
    done_seen = 0;
    pulse_start(f, n);
    for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
      if (ii < total_in) present(f, ii, total_in, bad);
      else begin
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
      end
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== held) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", m_tvalid, m_tdata, held);
        end
      end
      if (done) done_seen = 1;
      s_fire = s_tvalid && s_tready;
      m_fire = m_tvalid && m_tready;
      if (m_fire) begin
        p = k / wpp;
        rem = k % wpp;
        e = exp_word(p, rem / (f / 8), rem % (f / 8));
        got_q.push_back(m_tdata);
        n_checks++;
        if (m_tdata !== e || m_tlast !== (k == total_out - 1)) begin
          n_fail++;
          $display("FAIL out_word[%0d]: data=%h last=%b required data=%h last=%b", k, m_tdata, m_tlast, e, k == total_out - 1);
        end
        k++;
      end
      hold = m_tvalid && !m_tready;
      held = m_tdata;
      @(negedge clk);
      if (s_fire) ii++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    n_checks++;
    if (!done_seen || k != total_out) begin
      n_fail++;
      $display("FAIL frame_end: done_seen=%b outputs=%0d required done_seen=1 outputs=%0d", done_seen, k, total_out);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) px[0][r][c] = 8'(r * 8 + c);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || m_tkeep !== 4'hF || m_tuser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h last=%b done=%b err=%b keep=%h user=%b required 0,0,0,0,0,0,f,0",
               s_tready, m_tvalid, m_tdata, m_tlast, done, err, m_tkeep, m_tuser);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] req [4];
    req = '{32'h0F0D0B09, 32'h1F1D1B19, 32'h2F2D2B29, 32'h3F3D3B39};
    fill_ramp();
    run_frame(8, 1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== req[i]) begin
        n_fail++;
        $display("FAIL basic_word[%0d]: got=%h required=%h", i, got_q.size() > i ? got_q[i] : 32'hx, req[i]);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: err=%b required=0", err);
    end
  endtask

  task automatic test_negative();
    logic [31:0] req;
`ifdef MAXPOOL_RELU_EN
    req = 32'h00000000;
`else
    req = 32'hFFFFFFFF;
`endif
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) px[0][r][c] = 8'h80;
    for (int pr = 0; pr < 4; pr++)
      for (int pc = 0; pc < 4; pc++) px[0][2*pr + (pc & 1)][2*pc + (pr & 1)] = 8'hFF;
    run_frame(8, 1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== req) begin
        n_fail++;
        $display("FAIL negative_word[%0d]: got=%h required=%h", i, got_q.size() > i ? got_q[i] : 32'hx, req);
      end
    end
  endtask

  task automatic test_tlast_err();
    fill_ramp();
    run_frame(8, 1, 0, 4);
    n_checks++;
    if (err !== 1'b1 || got_q.size() != 4) begin
      n_fail++;
      $display("FAIL tlast_err: err=%b outputs=%0d required err=1 outputs=4", err, got_q.size());
    end
    run_frame(8, 1, 0, -1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL tlast_err_clear: err=%b required=0", err);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) px[p][r][c] = 8'($urandom);
    run_frame(32, 3, 1, -1);
    n_checks++;
    if (got_q.size() != 192 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_count: outputs=%0d err=%b required outputs=192 err=0", got_q.size(), err);
    end
  endtask

  task automatic test_reset_abort();
    int ii;
    bit fire;
    fill_ramp();
    pulse_start(8, 1);
    ii = 0;
    for (int cyc = 0; cyc < 50 && ii < 3; cyc++) begin
      present(8, ii, 16, -1);
      #1;
      fire = s_tvalid && s_tready;
      @(negedge clk);
      if (fire) ii++;
    end
    present(8, ii, 16, -1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ii != 3 || s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: accepted=%0d rdy=%b vld=%b data=%h last=%b done=%b err=%b required 3,0,0,0,0,0,0",
               ii, s_tready, m_tvalid, m_tdata, m_tlast, done, err);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    run_frame(8, 1, 0, -1);
    n_checks++;
    if (got_q.size() != 4 || got_q[0] !== 32'h0F0D0B09 || got_q[3] !== 32'h3F3D3B39) begin
      n_fail++;
      $display("FAIL abort_refresh: outputs=%0d first=%h required outputs=4 first=0f0d0b09", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_illegal();
    bit saw_done, saw_ready;
    saw_done = 0;
    saw_ready = 0;
    pulse_start(12, 1);
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err: err=%b required=1", err);
    end
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1;
      if (s_tready) saw_ready = 1;
    end
    s_tvalid = 1'b0;
    n_checks++;
    if (saw_done || saw_ready) begin
      n_fail++;
      $display("FAIL illegal_idle: done_seen=%b ready_seen=%b required 0,0", saw_done, saw_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_tlast_err();
    test_back_to_back();
    test_reset_abort();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
